// File: rtl/mod_n_pulse_counter.sv
// Modulo-MODULUS up/down counter of rising edges on an asynchronous pulse line.
// Latency: pulse_in rising before edge E1 updates count at E3; load takes effect on the next edge.
// No backpressure: events arriving while disabled or during a load are dropped, never queued.
module mod_n_pulse_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             pulse_in,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // Reject modulus values the count register cannot represent.
  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("mod_n_pulse_counter: MODULUS out of range for WIDTH");
  end

  // Synchronizer and edge-detect state.
  logic       s1;
  logic       s2;
  logic       s3;
  logic       armed;
  logic [1:0] primed;   // marks when s2 holds a real sample rather than its reset value
  logic       rise;

  // Next-state values and the toggle vector for the T flip-flops.
  logic [WIDTH-1:0] next_count;
  logic             next_tc;
  logic [WIDTH-1:0] toggle;

  // Two-flop synchronizer plus a third stage for edge detection. The detector
  // only arms once the synchronized line has been seen low after reset, so a
  // line already high when reset releases does not count as an event.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      primed <= 2'b00;
      armed  <= 1'b0;
    end else begin
      s1     <= pulse_in;
      s2     <= s1;
      s3     <= s2;
      primed <= {primed[0], 1'b1};
      armed  <= armed | (primed[1] & ~s2);
    end
  end

  assign rise = s2 & ~s3 & armed;

  // Next count and terminal-count flag: load beats counting, counting beats hold.
  always_comb begin
    next_count = count;
    next_tc    = 1'b0;
    if (load) begin
      // Out-of-range load values fall back to zero; a coincident rise is dropped.
      next_count = ({1'b0, load_value} < MOD_EXT) ? load_value : '0;
    end else if (enable && rise) begin
      if (up_down) begin
        // ">=" also pulls an out-of-range count back to zero on the next up event.
        if (count >= MAX_VAL) begin
          next_count = '0;
          next_tc    = 1'b1;
        end else begin
          next_count = count + ONE;
        end
      end else begin
        if (count == '0) begin
          next_count = MAX_VAL;
          next_tc    = 1'b1;
        end else begin
          next_count = count - ONE;
        end
      end
    end
  end

  // Each count bit is a T flip-flop: it flips wherever the next value differs.
  assign toggle = count ^ next_count;

  // Toggle-flop count register and registered one-cycle terminal-count pulse.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count ^ toggle;
      tc    <= next_tc;
    end
  end

endmodule

// File: tb/tb_mod_n_pulse_counter.sv
// Directed bench for mod_n_pulse_counter: load table, wrap sequences, reset and cascade cases.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every wait is a fixed number of cycles, so the run always reaches its summary.
module tb_mod_n_pulse_counter;

  logic       clock;
  logic       nReset;
  logic       pulse_in;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] count;
  logic       tc;

  // Two-stage cascade: stage 0 terminal count feeds stage 1 pulse input.
  logic       c_pulse;
  logic [3:0] c0_count;
  logic       c0_tc;
  logic [3:0] c1_count;
  logic       c1_tc;

  int n_cmp = 0;
  int n_bad = 0;

  mod_n_pulse_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clock      (clock),
    .nReset     (nReset),
    .pulse_in   (pulse_in),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .tc         (tc)
  );

  mod_n_pulse_counter #(.WIDTH(4), .MODULUS(10)) stage0 (
    .clock      (clock),
    .nReset     (nReset),
    .pulse_in   (c_pulse),
    .enable     (1'b1),
    .up_down    (1'b1),
    .load       (1'b0),
    .load_value (4'd0),
    .count      (c0_count),
    .tc         (c0_tc)
  );

  mod_n_pulse_counter #(.WIDTH(4), .MODULUS(10)) stage1 (
    .clock      (clock),
    .nReset     (nReset),
    .pulse_in   (c0_tc),
    .enable     (1'b1),
    .up_down    (1'b1),
    .load       (1'b0),
    .load_value (4'd0),
    .count      (c1_count),
    .tc         (c1_tc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] lv;
    logic [3:0] exp_count;
  } load_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_load(input logic [3:0] v);
    load       = 1'b1;
    load_value = v;
    @(negedge clock);
    load       = 1'b0;
  endtask

  // Plain pulse: high for nh cycles, then low for nl cycles.
  task automatic pulse(input int nh, input int nl);
    pulse_in = 1'b1;
    cycles(nh);
    pulse_in = 1'b0;
    cycles(nl);
  endtask

  // 3-high/3-low pulse checking that count holds two edges in and updates on the third.
  task automatic pulse_chk(input string nm, input int old_v, input int new_v, input int new_tc);
    pulse_in = 1'b1;
    cycles(2);
    chk({nm, " hold"}, 32'(count), 32'(old_v));
    cycles(1);
    chk({nm, " count"}, 32'(count), 32'(new_v));
    chk({nm, " tc"}, 32'(tc), 32'(new_tc));
    pulse_in = 1'b0;
    cycles(1);
    chk({nm, " tc after"}, 32'(tc), 32'd0);
    chk({nm, " count after"}, 32'(count), 32'(new_v));
    cycles(2);
  endtask

  // One cascade clock, counting stage-1 terminal-count pulses.
  task automatic casc_cycle(input logic p, inout int n_tc1);
    c_pulse = p;
    @(negedge clock);
    if (c1_tc) n_tc1++;
  endtask

  load_vec_t vecs[8];
  int tc1_seen;

  initial begin
    vecs[0] = '{4'd3,  4'd3};
    vecs[1] = '{4'd9,  4'd9};
    vecs[2] = '{4'd10, 4'd0};
    vecs[3] = '{4'd12, 4'd0};
    vecs[4] = '{4'd15, 4'd0};
    vecs[5] = '{4'd0,  4'd0};
    vecs[6] = '{4'd7,  4'd7};
    vecs[7] = '{4'd5,  4'd5};

    nReset     = 1'b0;
    pulse_in   = 1'b0;
    enable     = 1'b1;
    up_down    = 1'b1;
    load       = 1'b0;
    load_value = 4'd0;
    c_pulse    = 1'b0;
    tc1_seen   = 0;

    cycles(2);
    chk("reset count", 32'(count), 32'd0);
    chk("reset tc", 32'(tc), 32'd0);
    nReset = 1'b1;
    cycles(4);

    // Async reset mid-count, then release with the pulse line held high.
    do_load(4'd7);
    chk("pre-reset count", 32'(count), 32'd7);
    #2 nReset = 1'b0;
    #1;
    chk("async reset count", 32'(count), 32'd0);
    chk("async reset tc", 32'(tc), 32'd0);
    pulse_in = 1'b1;
    @(negedge clock);
    nReset = 1'b1;
    cycles(10);
    chk("held-high release", 32'(count), 32'd0);
    pulse_in = 1'b0;
    cycles(4);
    pulse(3, 3);
    chk("first fresh edge", 32'(count), 32'd1);

    // Up wrap from 0 through 9 back to 0.
    do_load(4'd0);
    up_down = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      pulse_chk("up", i - 1, i % 10, (i == 10) ? 1 : 0);
    end

    // Down wrap: 0 -> 9 with tc, then 9 -> 8 without.
    do_load(4'd0);
    up_down = 1'b0;
    pulse_chk("down wrap", 0, 9, 1);
    pulse_chk("down step", 9, 8, 0);
    up_down = 1'b1;

    // Load priority over a coincident rise; the rise is not deferred.
    do_load(4'd4);
    chk("load 4", 32'(count), 32'd4);
    pulse_in   = 1'b1;
    cycles(2);
    load       = 1'b1;
    load_value = 4'd6;
    cycles(1);
    load       = 1'b0;
    chk("load beats rise", 32'(count), 32'd6);
    chk("load tc", 32'(tc), 32'd0);
    cycles(2);
    chk("rise not deferred", 32'(count), 32'd6);
    pulse_in = 1'b0;
    cycles(3);

    // Load table, including out-of-range values.
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].lv);
      chk($sformatf("load table %0d count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("load table %0d tc", i), 32'(tc), 32'd0);
    end

    // Disabled events are dropped and not queued.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) pulse(3, 3);
    chk("disabled pulses", 32'(count), 32'd5);
    enable = 1'b1;
    cycles(5);
    chk("no queued events", 32'(count), 32'd5);

    // A long high level is one event.
    pulse(50, 3);
    chk("long pulse", 32'(count), 32'd6);

    // Cascade: 100 pulses into stage 0 wrap stage 1 exactly once.
    nReset = 1'b0;
    cycles(1);
    nReset = 1'b1;
    cycles(4);
    for (int p = 0; p < 50; p++) begin
      for (int c = 0; c < 6; c++) casc_cycle((c < 3) ? 1'b1 : 1'b0, tc1_seen);
    end
    for (int c = 0; c < 5; c++) casc_cycle(1'b0, tc1_seen);
    chk("cascade half s0", 32'(c0_count), 32'd0);
    chk("cascade half s1", 32'(c1_count), 32'd5);
    for (int p = 0; p < 50; p++) begin
      for (int c = 0; c < 6; c++) casc_cycle((c < 3) ? 1'b1 : 1'b0, tc1_seen);
    end
    for (int c = 0; c < 10; c++) casc_cycle(1'b0, tc1_seen);
    chk("cascade s0", 32'(c0_count), 32'd0);
    chk("cascade s1", 32'(c1_count), 32'd0);
    chk("cascade s1 tc count", 32'(tc1_seen), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
